// File: rtl/result_drain.sv
// result_drain: two-row result buffer between the accumulator FIFO and the
// write-back path. Full rows are captured whole and streamed out one lane
// per beat, sign-extended to OUT_BITS.
// Optional feature: define RESULT_DRAIN_RELU_EN to output negative lanes as 0
// and zero-extend non-negative lanes.
module result_drain #(
  parameter int LANES    = 16,
  parameter int ACC_BITS = 20,
  parameter int OUT_BITS = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*ACC_BITS-1:0] din,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [OUT_BITS-1:0]       m_data,
  output logic                      m_last,
  output logic [15:0]               rows_done
);

  localparam int            LW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  // Buffer occupancy doubles as the state: EMPTY/PARTIAL/FULL = 0/1/2 rows.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic                      wr_ptr_q, wr_ptr_d;
  logic                      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]             lane_cnt_q, lane_cnt_d;
  logic [15:0]               rows_done_q, rows_done_d;
  logic [LANES*ACC_BITS-1:0] row_q [2];
  logic [LANES*ACC_BITS-1:0] row_d [2];
  logic [ACC_BITS-1:0]       head_lane [LANES];
  logic [ACC_BITS-1:0]       lane_sel;
  logic                      push;
  logic                      beat;
  logic                      pop;

  genvar gi;

  // Row storage; cleared on reset so m_data reads 0 until the first row lands.
  for (gi = 0; gi < 2; gi++) begin : g_row
    // Entry gi takes din when it is the write target of an accepted push.
    always_comb begin
      row_d[gi] = row_q[gi];
      if (push && (wr_ptr_q == 1'(gi))) row_d[gi] = din;
    end

    // Entry gi storage register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) row_q[gi] <= '0;
      else          row_q[gi] <= row_d[gi];
    end
  end

  // Split the head row into lanes for the output mux.
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    assign head_lane[gi] = row_q[rd_ptr_q][gi*ACC_BITS +: ACC_BITS];
  end

  assign lane_sel  = head_lane[lane_cnt_q];
  assign rows_done = rows_done_q;

  // Lane widening: sign extension, or clamp-to-zero when ReLU is built in.
  always_comb begin
    m_data = '0;
`ifdef RESULT_DRAIN_RELU_EN
    if (!lane_sel[ACC_BITS-1]) m_data = OUT_BITS'(lane_sel);
`else
    m_data = OUT_BITS'($signed(lane_sel));
`endif
  end

  // Handshakes, pointer/lane advance and occupancy next-state.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    lane_cnt_d  = lane_cnt_q;
    rows_done_d = rows_done_q;

    // No bypass: a full buffer refuses a row even while its head is popping.
    in_ready = (state_q != FULL);
    m_valid  = (state_q != EMPTY);
    m_last   = m_valid && (lane_cnt_q == LAST_LANE);

    push = in_valid && in_ready;
    beat = m_valid && m_ready;
    pop  = beat && (lane_cnt_q == LAST_LANE);

    if (push) wr_ptr_d = ~wr_ptr_q;
    if (beat) lane_cnt_d = pop ? '0 : lane_cnt_q + 1'b1;
    if (pop) begin
      rd_ptr_d    = ~rd_ptr_q;
      rows_done_d = rows_done_q + 16'd1;
    end

    case (state_q)
      EMPTY:   if (push) state_d = PARTIAL;
      PARTIAL: begin
        if (push && !pop)      state_d = FULL;
        else if (!push && pop) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = PARTIAL;
      default: state_d = EMPTY;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      lane_cnt_q  <= '0;
      rows_done_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      lane_cnt_q  <= lane_cnt_d;
      rows_done_q <= rows_done_d;
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: scoreboard bench for result_drain. Accepted rows are
// expanded into expected beats by a lane-level model; a negedge monitor
// compares handshake flags, beats and the drained-row count.
// Build with RESULT_DRAIN_RELU_EN defined to check the ReLU variant.
module tb_result_drain;

  localparam int LANES    = 16;
  localparam int ACC_BITS = 20;
  localparam int OUT_BITS = 32;
  localparam int RW       = LANES * ACC_BITS;

  typedef struct {
    logic [OUT_BITS-1:0] data;
    bit                  last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] din = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [OUT_BITS-1:0] m_data;
  logic          m_last;
  logic [15:0]   rows_done;

  beat_t       exp_q [$];
  logic [15:0] model_rows_done = '0;
  int          checks = 0;
  int          errors = 0;

  result_drain #(.LANES(LANES), .ACC_BITS(ACC_BITS), .OUT_BITS(OUT_BITS)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .rows_done(rows_done)
  );

  always #5 clk = ~clk;

  // Expected output word for one raw lane, from its integer value.
  function automatic logic [OUT_BITS-1:0] model_lane(input logic [ACC_BITS-1:0] raw);
    int v;
    v = int'(raw);
    if (raw[ACC_BITS-1]) v = v - (1 << ACC_BITS);
`ifdef RESULT_DRAIN_RELU_EN
    if (v < 0) v = 0;
`endif
    return OUT_BITS'(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare against the model, then advance it for the coming edge.
  always @(negedge clk) begin
    int rows;
    if (!reset_n) begin
      exp_q.delete();
      model_rows_done = '0;
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_last", 64'(m_last), 64'd0);
      check("rst_rows_done", 64'(rows_done), 64'd0);
    end else begin
      rows = (exp_q.size() + LANES - 1) / LANES;
      check("in_ready", 64'(in_ready), 64'(rows != 2));
      check("m_valid", 64'(m_valid), 64'(rows != 0));
      check("rows_done", 64'(rows_done), 64'(model_rows_done));
      if (rows != 0) begin
        check("m_data", 64'(m_data), 64'(exp_q[0].data));
        check("m_last", 64'(m_last), 64'(exp_q[0].last));
        if (m_ready) begin
          if (exp_q[0].last) model_rows_done = model_rows_done + 16'd1;
          void'(exp_q.pop_front());
        end
      end else begin
        check("m_last_idle", 64'(m_last), 64'd0);
      end
      if (in_valid && rows != 2) begin
        for (int k = 0; k < LANES; k++) begin
          beat_t b;
          b.data = model_lane(din[k*ACC_BITS +: ACC_BITS]);
          b.last = (k == LANES - 1);
          exp_q.push_back(b);
        end
      end
    end
  end

  task automatic push_row(input logic [RW-1:0] row);
    int n;
    n = 0;
    in_valid = 1'b1;
    din = row;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 3000) begin
        errors++;
        $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles", n);
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        errors++;
        $display("FAIL drain_timeout: %0d beats outstanding", exp_q.size());
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    logic [ACC_BITS-1:0] v;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      case ($urandom_range(0, 5))
        0:       v = 20'h80000;
        1:       v = 20'h7FFFF;
        2:       v = 20'hFFFFF;
        3:       v = 20'h00000;
        default: v = ACC_BITS'($urandom);
      endcase
      r[k*ACC_BITS +: ACC_BITS] = v;
    end
    return r;
  endfunction

  initial begin
    logic [RW-1:0] row;
    bit            drv_done;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_m_data", 64'(m_data), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Counting row drained at full rate
    m_ready = 1'b1;
    for (int k = 0; k < LANES; k++) row[k*ACC_BITS +: ACC_BITS] = ACC_BITS'(k + 1);
    @(posedge clk); #1;
    push_row(row);
    wait_drain();
    check("rows_after_first", 64'(rows_done), 64'd1);

    // Sign-extension corners in lanes 0 and 1
    row = rand_row();
    row[0 +: ACC_BITS]        = 20'hFFFFF;
    row[ACC_BITS +: ACC_BITS] = 20'h80000;
    push_row(row);
    wait_drain();

    // Back-pressure: three rows offered while the sink stalls
    m_ready = 1'b0;
    fork
      begin
        push_row(rand_row());
        push_row(rand_row());
        push_row(rand_row());
      end
      begin
        repeat (12) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    wait_drain();

    // Sink toggles every cycle over two rows
    m_ready = 1'b0;
    fork
      begin
        push_row(rand_row());
        push_row(rand_row());
      end
      begin
        repeat (80) begin
          @(posedge clk);
          #1 m_ready = ~m_ready;
        end
        m_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset after five beats of row 0 with row 1 buffered
    m_ready = 1'b0;
    push_row(rand_row());
    push_row(rand_row());
    m_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    push_row(rand_row());
    wait_drain();
    check("rows_after_reset", 64'(rows_done), 64'd1);

    // Randomised traffic with random back-pressure and input gaps
    drv_done = 1'b0;
    fork
      begin
        for (int r = 0; r < 30; r++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          push_row(rand_row());
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1 m_ready = ($urandom_range(0, 9) < 6);
        end
        m_ready = 1'b1;
      end
    join
    wait_drain();
    check("rows_final", 64'(rows_done), 64'(model_rows_done));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
